cache_miss_ctrl: RTL and testbench
==================================

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of data words, addresses and counters.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpu_req  input  1  load/store request valid from memory stage.
REQ-005 cpu_we  input  1  1 = store, 0 = load.
REQ-006 cpu_addr  input  DATA_WIDTH  byte address; bits [1:0] ignored (word access only).
REQ-007 cpu_wdata  input  DATA_WIDTH  store data.
REQ-008 cache_hit  input  1  hit indication from the two-way cache for cpu_addr.
REQ-009 cache_rdata  input  DATA_WIDTH  cache read data for cpu_addr.
REQ-010 stall  output  1  freeze pipeline; CPU holds cpu_* stable while high.
REQ-011 cpu_rdata  output  DATA_WIDTH  load result.
REQ-012 fill_en  output  1  one-cycle cache write strobe (drives the cache's overwrite/fill path).
REQ-013 fill_addr  output  DATA_WIDTH  word-aligned address for the cache write.
REQ-014 fill_data  output  DATA_WIDTH  data for the cache write.
REQ-015 mem_req  output  1  main-memory request valid.
REQ-016 mem_we  output  1  main-memory write enable.
REQ-017 mem_addr  output  DATA_WIDTH  {addr[31:2],2'b00}.
REQ-018 mem_wdata  output  DATA_WIDTH  main-memory write data.
REQ-019 mem_ack  input  1  one-cycle completion pulse; mem_rdata valid in that cycle.
REQ-020 mem_rdata  input  DATA_WIDTH  main-memory read data.
REQ-021 hit_count, miss_count  output  DATA_WIDTH each  load hit/miss counters.

Function
REQ-022 FSM states SHALL be IDLE, MEM_RD, MEM_WR, RESP; write-through, no write-allocate policy.
REQ-023 IDLE, cpu_req=1, cpu_we=0, cache_hit=1: cpu_rdata=cache_rdata combinationally, stall=0, hit_count+1, remain IDLE.
REQ-024 IDLE, cpu_req=1, cpu_we=0, cache_hit=0: stall=1 same cycle, latch aligned address, miss_count+1, go MEM_RD.
REQ-025 IDLE, cpu_req=1, cpu_we=1: stall=1 same cycle, latch address, wdata and cache_hit (as hit_l), go MEM_WR.
REQ-026 MEM_RD: mem_req=1, mem_we=0, mem_addr=latched address, stall=1; on mem_ack capture mem_rdata into rdata_l, go RESP.
REQ-027 MEM_WR: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched values, stall=1; on mem_ack go RESP.
REQ-028 mem_req/mem_addr/mem_wdata SHALL remain stable from first assertion until the mem_ack cycle inclusive; mem_ack allowed in the first request cycle.
REQ-029 RESP after read: stall=0, cpu_rdata=rdata_l, fill_en=1, fill_addr=latched address, fill_data=rdata_l.
REQ-030 RESP after write: stall=0, fill_en=hit_l, fill_data=latched wdata (updates cached copy only on store hit).
REQ-031 RESP SHALL ignore cpu_req and return to IDLE unconditionally; next request accepted the following cycle.
REQ-032 Minimum latency: read miss stall=1 for 2 cycles (accept, MEM_RD with ack), data in cycle 3; each extra memory wait cycle adds 1.
REQ-033 mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-034 fill_en SHALL be 0 in all states except RESP.
REQ-035 Counters SHALL saturate at all-ones; no wrap.
REQ-036 IDLE with cpu_req=0: stall=0, fill_en=0, mem_req=0, counters unchanged.
REQ-037 cpu_rdata SHALL be 0 when not in the IDLE read-hit or RESP-read conditions.

Reset
REQ-038 rst=1 at posedge SHALL force IDLE, clear latches, hit_count=0, miss_count=0; outputs then: stall=0, fill_en=0, mem_req=0, mem_we=0, cpu_rdata=0.
REQ-039 Reset mid-transaction SHALL abandon it: mem_req low the cycle after the reset edge, no fill_en, a later stray mem_ack ignored.

Verification
REQ-040 Load hit: cpu_req=1, cpu_we=0, cache_hit=1, cache_rdata=0xDEADBEEF -> same cycle cpu_rdata=0xDEADBEEF, stall=0, hit_count 0->1.
REQ-041 Load miss, 3-cycle memory: addr 0x00000107 -> mem_addr=0x00000104; ack with 0x12345678 -> RESP fill_en=1, fill_addr=0x104, cpu_rdata=0x12345678; stall high exactly 4 cycles; miss_count=1.
REQ-042 Store hit then store miss: wdata 0xA5A5A5A5 -> mem_we=1 both; fill_en=1 in RESP only for the hit case, fill_data=0xA5A5A5A5.
REQ-043 Zero-wait ack: ack in first MEM_RD cycle -> stall high 2 cycles, RESP in cycle 3; back-to-back load accepted the cycle after RESP.
REQ-044 rst asserted during MEM_RD with ack pending -> next cycle IDLE, mem_req=0, counters 0; ack driven afterwards produces no fill_en.
REQ-045 Saturation: force miss_count=0xFFFFFFFF via 2^32 misses or backdoor preload -> one further miss leaves 0xFFFFFFFF.

Source files
------------

// File: rtl/cache_miss_ctrl_if.sv
// CPU / cache / main-memory signal bundle for the blocking cache miss controller.
interface cache_miss_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_rdata;
  logic                  stall;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  fill_en;
  logic [DATA_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] hit_count;
  logic [DATA_WIDTH-1:0] miss_count;

  // Environment side: CPU pipeline, cache arrays and main memory.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata,
           mem_ack, mem_rdata,
    input  stall, cpu_rdata, fill_en, fill_addr, fill_data,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  // Controller side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata,
           mem_ack, mem_rdata,
    output stall, cpu_rdata, fill_en, fill_addr, fill_data,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Blocking write-through / no-write-allocate miss controller for a two-way cache.
// Load hits complete in IDLE; load misses and all stores go to main memory.
module cache_miss_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  cache_miss_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    MEM_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX    = '1;

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] addr_l;
  logic [DATA_WIDTH-1:0] wdata_l;
  logic [DATA_WIDTH-1:0] rdata_l;
  logic                  hit_l;
  logic                  we_l;
  logic [DATA_WIDTH-1:0] hit_count_q;
  logic [DATA_WIDTH-1:0] miss_count_q;

  logic load_hit_c;
  logic accept_miss_c;

  assign load_hit_c    = (state_q == IDLE) && bus.cpu_req && !bus.cpu_we && bus.cache_hit;
  assign accept_miss_c = (state_q == IDLE) && bus.cpu_req && !load_hit_c;

  // State, transaction latches and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_l       <= '0;
      wdata_l      <= '0;
      rdata_l      <= '0;
      hit_l        <= 1'b0;
      we_l         <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_n;
      if (load_hit_c && (hit_count_q != CNT_MAX)) begin
        hit_count_q <= hit_count_q + DATA_WIDTH'(1);
      end
      if (accept_miss_c) begin
        addr_l  <= bus.cpu_addr & ALIGN_MASK;
        wdata_l <= bus.cpu_wdata;
        hit_l   <= bus.cpu_we & bus.cache_hit;
        we_l    <= bus.cpu_we;
        if (!bus.cpu_we && (miss_count_q != CNT_MAX)) begin
          miss_count_q <= miss_count_q + DATA_WIDTH'(1);
        end
      end
      if ((state_q == MEM_RD) && bus.mem_ack) begin
        rdata_l <= bus.mem_rdata;
      end
    end
  end

  // Next state and handshake outputs; stall and load data respond in the same cycle.
  always_comb begin
    state_n       = state_q;
    bus.stall     = 1'b0;
    bus.cpu_rdata = '0;
    bus.fill_en   = 1'b0;
    bus.fill_addr = '0;
    bus.fill_data = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (load_hit_c) begin
          bus.cpu_rdata = bus.cache_rdata;
        end else if (bus.cpu_req) begin
          bus.stall = 1'b1;
          state_n   = bus.cpu_we ? MEM_WR : MEM_RD;
        end
      end
      MEM_RD: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_l;
        if (bus.mem_ack) state_n = RESP;
      end
      MEM_WR: begin
        bus.stall     = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_l;
        bus.mem_wdata = wdata_l;
        if (bus.mem_ack) state_n = RESP;
      end
      RESP: begin
        bus.fill_addr = addr_l;
        if (we_l) begin
          // Store only refreshes a copy that is already cached.
          bus.fill_en   = hit_l;
          bus.fill_data = wdata_l;
        end else begin
          bus.cpu_rdata = rdata_l;
          bus.fill_en   = 1'b1;
          bus.fill_data = rdata_l;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed self-checking bench for cache_miss_ctrl.
module tb_cache_miss_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   sc;

  cache_miss_ctrl_if #(.DATA_WIDTH(32)) bus ();

  cache_miss_ctrl #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = '0;
    bus.cache_hit   = 1'b0;
    bus.cache_rdata = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.fill_en !== 1'b0 || bus.mem_req !== 1'b0 ||
        bus.mem_we !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got stall=%b fill_en=%b mem_req=%b mem_we=%b cpu_rdata=%h exp all zero",
               bus.stall, bus.fill_en, bus.mem_req, bus.mem_we, bus.cpu_rdata);
    end
    checks++;
    if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_counters got hit=%h miss=%h exp 0/0", bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_load_hit();
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cache_hit = 1'b1;
    bus.cpu_addr = 32'h0000_0010; bus.cache_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.cpu_rdata !== 32'hDEAD_BEEF || bus.stall !== 1'b0 || bus.hit_count !== 32'h0) begin
      failures++;
      $display("FAIL load_hit got rdata=%h stall=%b hit=%h exp deadbeef/0/0",
               bus.cpu_rdata, bus.stall, bus.hit_count);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.hit_count !== 32'h1 || bus.cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL load_hit_count got hit=%h rdata=%h exp 1/0", bus.hit_count, bus.cpu_rdata);
    end
  endtask

  task automatic test_load_miss();
    sc = 0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cache_hit = 1'b0;
    bus.cpu_addr = 32'h0000_0107;
    #1;
    if (bus.stall === 1'b1) sc++;
    checks++;
    if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL miss_accept got stall=%b mem_req=%b exp 1/0", bus.stall, bus.mem_req);
    end
    @(negedge clk);
    #1;
    if (bus.stall === 1'b1) sc++;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0000_0104) begin
      failures++;
      $display("FAIL miss_mem_req got req=%b we=%b addr=%h exp 1/0/00000104",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    #1;
    if (bus.stall === 1'b1) sc++;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    #1;
    if (bus.stall === 1'b1) sc++;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0104 || bus.fill_en !== 1'b0) begin
      failures++;
      $display("FAIL miss_ack_cycle got req=%b addr=%h fill_en=%b exp 1/00000104/0",
               bus.mem_req, bus.mem_addr, bus.fill_en);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    #1;
    if (bus.stall === 1'b1) sc++;
    checks++;
    if (bus.stall !== 1'b0 || bus.fill_en !== 1'b1 || bus.fill_addr !== 32'h0000_0104 ||
        bus.fill_data !== 32'h1234_5678 || bus.cpu_rdata !== 32'h1234_5678 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL miss_resp got stall=%b fill_en=%b fill_addr=%h fill_data=%h rdata=%h mem_req=%b exp 0/1/104/12345678/12345678/0",
               bus.stall, bus.fill_en, bus.fill_addr, bus.fill_data, bus.cpu_rdata, bus.mem_req);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (sc != 4 || bus.miss_count !== 32'h1 || bus.stall !== 1'b0 || bus.fill_en !== 1'b0) begin
      failures++;
      $display("FAIL miss_latency got stall_cycles=%0d miss=%h stall=%b fill_en=%b exp 4/1/0/0",
               sc, bus.miss_count, bus.stall, bus.fill_en);
    end
  endtask

  task automatic test_store(input logic hit, input logic [31:0] addr, input string name);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cache_hit = hit;
    bus.cpu_addr = addr; bus.cpu_wdata = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.fill_en !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept got stall=%b fill_en=%b exp 1/0", name, bus.stall, bus.fill_en);
    end
    @(negedge clk);
    bus.cache_hit = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== addr ||
        bus.mem_wdata !== 32'hA5A5_A5A5 || bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL %s_mem got req=%b we=%b addr=%h wdata=%h stall=%b exp 1/1/%h/a5a5a5a5/1",
               name, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.stall, addr);
    end
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.fill_en !== hit || bus.fill_data !== 32'hA5A5_A5A5 ||
        bus.cpu_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s_resp got stall=%b fill_en=%b fill_data=%h rdata=%h mem_req=%b exp 0/%b/a5a5a5a5/0/0",
               name, bus.stall, bus.fill_en, bus.fill_data, bus.cpu_rdata, bus.mem_req, hit);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.miss_count !== 32'h1 || bus.hit_count !== 32'h1) begin
      failures++;
      $display("FAIL %s_counters got hit=%h miss=%h exp 1/1", name, bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cache_hit = 1'b0;
    bus.cpu_addr = 32'h0000_0042;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.mem_addr !== 32'h0000_0040) begin
      failures++;
      $display("FAIL zw_mem got stall=%b addr=%h exp 1/00000040", bus.stall, bus.mem_addr);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.cache_hit = 1'b1; bus.cache_rdata = 32'h3333_4444;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.cpu_rdata !== 32'h1111_2222 || bus.fill_en !== 1'b1) begin
      failures++;
      $display("FAIL zw_resp got stall=%b rdata=%h fill_en=%b exp 0/11112222/1",
               bus.stall, bus.cpu_rdata, bus.fill_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.cpu_rdata !== 32'h3333_4444 || bus.fill_en !== 1'b0 ||
        bus.hit_count !== 32'h1 || bus.miss_count !== 32'h2) begin
      failures++;
      $display("FAIL b2b_hit got stall=%b rdata=%h fill_en=%b hit=%h miss=%h exp 0/33334444/0/1/2",
               bus.stall, bus.cpu_rdata, bus.fill_en, bus.hit_count, bus.miss_count);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.hit_count !== 32'h2) begin
      failures++;
      $display("FAIL b2b_hit_count got %h exp 00000002", bus.hit_count);
    end
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.fill_en !== 1'b0 || bus.mem_req !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL stray_ack got stall=%b fill_en=%b mem_req=%b rdata=%h exp 0/0/0/0",
               bus.stall, bus.fill_en, bus.mem_req, bus.cpu_rdata);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.fill_en !== 1'b0 || bus.hit_count !== 32'h2 || bus.miss_count !== 32'h2) begin
      failures++;
      $display("FAIL stray_ack_after got fill_en=%b hit=%h miss=%h exp 0/2/2",
               bus.fill_en, bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cache_hit = 1'b0;
    bus.cpu_addr = 32'h0000_0080;
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre got mem_req=%b exp 1", bus.mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_idle got mem_req=%b stall=%b hit=%h miss=%h exp 0/0/0/0",
               bus.mem_req, bus.stall, bus.hit_count, bus.miss_count);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.fill_en !== 1'b0 || bus.cpu_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_late_ack got fill_en=%b rdata=%h mem_req=%b exp 0/0/0",
               bus.fill_en, bus.cpu_rdata, bus.mem_req);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    dut.miss_count_q = 32'hFFFF_FFFF;
    dut.hit_count_q  = 32'hFFFF_FFFF;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cache_hit = 1'b0;
    bus.cpu_addr = 32'h0000_0500;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.cache_hit = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.miss_count !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sat_miss got %h exp ffffffff", bus.miss_count);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.hit_count !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sat_hit got %h exp ffffffff", bus.hit_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_load_hit();
    test_load_miss();
    test_store(1'b1, 32'h0000_0200, "store_hit");
    test_store(1'b0, 32'h0000_0300, "store_miss");
    test_back_to_back();
    test_stray_ack();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
